// File: rtl/fb_pkg.sv
// Shared constants and slot encoding for the framebuffer scan-out arbiter.
package fb_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned H_MAX    = 840;
    localparam int unsigned V_MAX    = 500;
    localparam int unsigned BPP      = 4;
    localparam int unsigned PPW      = 4;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_DISP,
        SLOT_WR,
        SLOT_RD
    } slot_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO with asynchronous reset; DEPTH must be a power of two (>= 2).
module fb_wr_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (o_count == CW'(DEPTH));
    assign o_empty = (o_count == '0);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   o_count <= o_count + CW'(1);
                2'b01:   o_count <= o_count - CW'(1);
                default: o_count <= o_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Single-port framebuffer arbiter: display fetch slots win, host writes drain in free slots.
// Optional host read port enabled by defining FB_HOST_READ_EN.
module fb_scanout_arbiter #(
    parameter int unsigned H_ACTIVE      = fb_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE      = fb_pkg::V_ACTIVE,
    parameter int unsigned H_MAX         = fb_pkg::H_MAX,
    parameter int unsigned V_MAX         = fb_pkg::V_MAX,
    parameter int unsigned BPP           = fb_pkg::BPP,
    parameter int unsigned PPW           = fb_pkg::PPW,
    parameter int unsigned AW            = 17,
    parameter int unsigned WR_FIFO_DEPTH = 4,
    localparam int unsigned DW           = BPP * PPW
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [10:0]    i_h_counter,
    input  logic [9:0]     i_v_counter,
    output logic [BPP-1:0] o_pixel,
    output logic           o_pixel_valid,
    input  logic           i_wr_valid,
    input  logic [AW-1:0]  i_wr_addr,
    input  logic [DW-1:0]  i_wr_data,
    output logic           o_wr_ready,
    output logic [AW-1:0]  o_ram_addr,
    output logic           o_ram_we,
    output logic [DW-1:0]  o_ram_wdata,
    input  logic [DW-1:0]  i_ram_rdata
`ifdef FB_HOST_READ_EN
    ,
    input  logic           i_rd_valid,
    input  logic [AW-1:0]  i_rd_addr,
    output logic           o_rd_ready,
    output logic [DW-1:0]  o_rd_data,
    output logic           o_rd_data_valid
`endif
);

    import fb_pkg::*;

    localparam int unsigned CW = $clog2(WR_FIFO_DEPTH) + 1;

    logic [10:0]    xn;
    logic [9:0]     ln;
    logic           disp_slot;
    logic           frame_start;
    slot_e          slot;

    logic [AW-1:0]  r_disp_addr;
    logic           r_synced;
    logic           r_load;
    logic [DW-1:0]  r_shift;

    logic           wr_full;
    logic           wr_empty;
    logic [CW-1:0]  wr_count;
    logic           wr_pop;
    logic [AW+DW-1:0] wr_head;

    fb_wr_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (WR_FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_wr_valid && !wr_full),
        .i_data  ({i_wr_addr, i_wr_data}),
        .i_pop   (wr_pop),
        .o_data  (wr_head),
        .o_full  (wr_full),
        .o_empty (wr_empty),
        .o_count (wr_count)
    );

    assign o_wr_ready = (wr_count != CW'(WR_FIFO_DEPTH));

    // Two-cycle lookahead so the registered RAM's data lands just before the pixel is shown.
    always_comb begin
        if (i_h_counter == 11'(H_MAX - 1))  xn = '0;
        else if (i_h_counter == 11'(H_MAX)) xn = 11'd1;
        else                                xn = i_h_counter + 11'd2;
        ln = i_v_counter;
        if (i_h_counter >= 11'(H_MAX - 1))
            ln = (i_v_counter == 10'(V_MAX)) ? '0 : i_v_counter + 10'd1;
    end

    assign disp_slot   = (xn < 11'(H_ACTIVE)) && ((32'(xn) % PPW) == 0) && (ln < 10'(V_ACTIVE));
    assign frame_start = disp_slot && (xn == '0) && (ln == '0);

`ifdef FB_HOST_READ_EN
    logic           rd_pending;
    logic           prefer_rd;
    logic           rd_cap;
    logic [AW-1:0]  r_rd_addr;

    assign o_rd_ready = !rd_pending;
`endif

    always_comb begin
        slot = SLOT_IDLE;
        if (disp_slot)
            slot = SLOT_DISP;
`ifdef FB_HOST_READ_EN
        else if (rd_pending && !wr_empty)
            slot = prefer_rd ? SLOT_RD : SLOT_WR;
        else if (rd_pending)
            slot = SLOT_RD;
`endif
        else if (!wr_empty)
            slot = SLOT_WR;
    end

    always_comb begin
        o_ram_addr  = '0;
        o_ram_we    = 1'b0;
        o_ram_wdata = '0;
        wr_pop      = 1'b0;
        case (slot)
            SLOT_DISP: o_ram_addr = frame_start ? '0 : r_disp_addr;
            SLOT_WR: begin
                o_ram_addr  = wr_head[AW+DW-1:DW];
                o_ram_wdata = wr_head[DW-1:0];
                o_ram_we    = 1'b1;
                wr_pop      = 1'b1;
            end
`ifdef FB_HOST_READ_EN
            SLOT_RD:   o_ram_addr = r_rd_addr;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_disp_addr <= '0;
            r_synced    <= 1'b0;
            r_load      <= 1'b0;
            r_shift     <= '0;
        end else begin
            r_load <= disp_slot;
            if (disp_slot)
                r_disp_addr <= frame_start ? AW'(1) : r_disp_addr + AW'(1);
            if (frame_start)
                r_synced <= 1'b1;
            if (r_load) r_shift <= i_ram_rdata;
            else        r_shift <= r_shift >> BPP;
        end
    end

    assign o_pixel_valid = !i_rst && (i_h_counter < 11'(H_ACTIVE)) && (i_v_counter < 10'(V_ACTIVE));
    assign o_pixel       = (o_pixel_valid && r_synced) ? r_shift[BPP-1:0] : '0;

`ifdef FB_HOST_READ_EN
    // Round-robin state only moves when a read and a write actually contend.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_pending      <= 1'b0;
            prefer_rd       <= 1'b0;
            rd_cap          <= 1'b0;
            r_rd_addr       <= '0;
            o_rd_data       <= '0;
            o_rd_data_valid <= 1'b0;
        end else begin
            if (slot == SLOT_RD)
                rd_pending <= 1'b0;
            else if (i_rd_valid && !rd_pending) begin
                rd_pending <= 1'b1;
                r_rd_addr  <= i_rd_addr;
            end
            if (!disp_slot && rd_pending && !wr_empty)
                prefer_rd <= (slot == SLOT_WR);
            rd_cap          <= (slot == SLOT_RD);
            o_rd_data_valid <= rd_cap;
            if (rd_cap)
                o_rd_data <= i_ram_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Randomized bench for fb_scanout_arbiter against a position/queue based reference model.
module tb_fb_scanout_arbiter;
    import fb_pkg::*;

    localparam int unsigned AW    = 17;
    localparam int unsigned DW    = BPP * PPW;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned HT    = H_MAX + 1;
    localparam int unsigned VT    = V_MAX + 1;
    localparam int unsigned WPL   = H_ACTIVE / PPW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [10:0]    h_cnt = '0;
    logic [9:0]     v_cnt = '0;
    logic [BPP-1:0] pixel;
    logic           pixel_valid;
    logic           wr_valid = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           wr_ready;
    logic [AW-1:0]  ram_addr;
    logic           ram_we;
    logic [DW-1:0]  ram_wdata;
    logic [DW-1:0]  ram_rdata = '0;
`ifdef FB_HOST_READ_EN
    logic           rd_valid = 1'b0;
    logic [AW-1:0]  rd_addr = '0;
    logic           rd_ready;
    logic [DW-1:0]  rd_data;
    logic           rd_data_valid;
`endif

    int rate     = 0;
    bit model_en = 1'b1;
    bit chk_ffff = 1'b0;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fb_scanout_arbiter #(
        .H_ACTIVE      (H_ACTIVE),
        .V_ACTIVE      (V_ACTIVE),
        .H_MAX         (H_MAX),
        .V_MAX         (V_MAX),
        .BPP           (BPP),
        .PPW           (PPW),
        .AW            (AW),
        .WR_FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_h_counter     (h_cnt),
        .i_v_counter     (v_cnt),
        .o_pixel         (pixel),
        .o_pixel_valid   (pixel_valid),
        .i_wr_valid      (wr_valid),
        .i_wr_addr       (wr_addr),
        .i_wr_data       (wr_data),
        .o_wr_ready      (wr_ready),
        .o_ram_addr      (ram_addr),
        .o_ram_we        (ram_we),
        .o_ram_wdata     (ram_wdata),
        .i_ram_rdata     (ram_rdata)
`ifdef FB_HOST_READ_EN
        ,
        .i_rd_valid      (rd_valid),
        .i_rd_addr       (rd_addr),
        .o_rd_ready      (rd_ready),
        .o_rd_data       (rd_data),
        .o_rd_data_valid (rd_data_valid)
`endif
    );

    function automatic logic [DW-1:0] init_word(input int unsigned a);
        return (a == 0) ? DW'(16'h4321) : DW'(a * 32'h9E37 + 32'h1234);
    endfunction

    // Registered single-port RAM; unwritten words hold init_word(addr).
    logic [DW-1:0] ram    [0:(1<<AW)-1];
    bit            ram_wr [0:(1<<AW)-1];
    always @(posedge clk) begin
        ram_rdata <= ram_wr[ram_addr] ? ram[ram_addr] : init_word(int'(ram_addr));
        if (ram_we) begin
            ram[ram_addr]    <= ram_wdata;
            ram_wr[ram_addr] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at h=%0d v=%0d", tag, obs, exp, h_cnt, v_cnt);
        end
    endtask

    // Reference model: framebuffer contents, pending host writes, and the pixels each fetch promises.
    logic [DW-1:0]    fb_m  [0:(1<<AW)-1];
    bit               fb_wr [0:(1<<AW)-1];
    logic [AW+DW-1:0] q [$];
    logic [BPP-1:0]   exp_pix [0:H_ACTIVE-1];
    bit               m_sync = 1'b0;

    always @(negedge clk) begin
        int unsigned p, xn, ln, sz, a;
        bit disp, vis;
        logic [DW-1:0] w;
        logic [AW+DW-1:0] hd;
        p    = (int'(v_cnt) * HT + int'(h_cnt) + 2) % (HT * VT);
        xn   = p % HT;
        ln   = p / HT;
        disp = (xn < H_ACTIVE) && (xn % PPW == 0) && (ln < V_ACTIVE);
        vis  = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
        if (rst) begin
            q.delete();
            m_sync = 1'b0;
            chk("rst_pixel", 32'(pixel), 0);
            chk("rst_pvalid", 32'(pixel_valid), 0);
            chk("rst_we", 32'(ram_we), 0);
            chk("rst_addr", 32'(ram_addr), 0);
            chk("rst_ready", 32'(wr_ready), 1);
        end else begin
            sz = q.size();
            chk("wr_ready", 32'(wr_ready), 32'(sz < DEPTH));
            chk("pvalid", 32'(pixel_valid), 32'(vis));
            if (model_en)
                chk("pixel", 32'(pixel), (vis && m_sync) ? 32'(exp_pix[h_cnt]) : 0);
            if (model_en && m_sync && v_cnt == 0 && h_cnt < 4)
                chk("px_init", 32'(pixel), 32'(h_cnt) + 1);
            if (chk_ffff && m_sync && v_cnt == 0 && h_cnt >= 20 && h_cnt <= 23)
                chk("px_ffff", 32'(pixel), 15);
            if (disp) begin
                chk("disp_we", 32'(ram_we), 0);
                if (xn == 0 && ln == 0) m_sync = 1'b1;
                if (m_sync && model_en) begin
                    a = ln * WPL + xn / PPW;
                    chk("disp_addr", 32'(ram_addr), a);
                    if (xn == H_ACTIVE - PPW && ln == 0) chk("slot159", 32'(ram_addr), 159);
                    if (xn == H_ACTIVE - PPW && ln == 1) chk("slot319", 32'(ram_addr), 319);
                    w = fb_wr[a] ? fb_m[a] : init_word(a);
                    for (int unsigned k = 0; k < PPW; k++)
                        exp_pix[xn + k] = BPP'(w >> (BPP * k));
                end
            end else if (sz > 0) begin
                hd = q.pop_front();
                chk("wr_we", 32'(ram_we), 1);
                chk("wr_addr", 32'(ram_addr), 32'(hd[AW+DW-1:DW]));
                chk("wr_data", 32'(ram_wdata), 32'(hd[DW-1:0]));
                fb_m[hd[AW+DW-1:DW]]  = hd[DW-1:0];
                fb_wr[hd[AW+DW-1:DW]] = 1'b1;
            end else begin
                chk("idle_we", 32'(ram_we), 0);
            end
            if (wr_valid && sz < DEPTH)
                q.push_back({wr_addr, wr_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (h_cnt == 11'(H_MAX)) begin
            h_cnt = '0;
            v_cnt = (v_cnt == 10'(V_MAX)) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt = h_cnt + 11'd1;
        end
        wr_valid = ($urandom_range(99) < rate);
        wr_addr  = AW'($urandom_range(479, 8));
        wr_data  = DW'($urandom);
    endtask

    task automatic run_until(input int unsigned ht, input int unsigned vt);
        for (int unsigned i = 0; i < HT * VT; i++) begin
            if (h_cnt == 11'(ht) && v_cnt == 10'(vt)) return;
            tick();
        end
        chk("run_bound", {h_cnt, v_cnt}, {11'(ht), 10'(vt)});
    endtask

    task automatic jump(input int unsigned ht, input int unsigned vt);
        h_cnt = 11'(ht);
        v_cnt = 10'(vt);
    endtask

    initial begin
        jump(830, 500);
        repeat (3) tick();
        rst = 1'b0;
        run_until(H_MAX, 2);

        jump(600, 500);
        wr_valid = 1'b1;
        wr_addr  = AW'(5);
        wr_data  = DW'(16'hFFFF);
        tick();
        @(negedge clk);
        chk("blank_wr_we", 32'(ram_we), 1);
        chk("blank_wr_addr", 32'(ram_addr), 5);
        chk_ffff = 1'b1;
        run_until(H_MAX, 2);
        chk_ffff = 1'b0;

        for (int f = 0; f < 3; f++) begin
            jump(820, 500);
            rate = 60;
            run_until(H_MAX, 0);
            rate = 95;
            run_until(H_MAX, 1);
            rate = 30;
            run_until(H_MAX, 2);
            rate = 0;
        end

        model_en = 1'b0;
        jump(280, 100);
        rate = 95;
        run_until(300, 100);
        rate = 0;
        wr_valid = 1'b0;
        rst = 1'b1;
        model_en = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        rate = 50;
        run_until(H_MAX, 101);
        rate = 0;
        jump(820, 500);
        run_until(H_MAX, 1);

`ifdef FB_HOST_READ_EN
        jump(600, 500);
        wr_valid = 1'b1;
        wr_addr  = AW'(9);
        wr_data  = DW'(16'hA5A5);
        rd_valid = 1'b1;
        rd_addr  = AW'(7);
        tick();
        rd_valid = 1'b0;
        @(negedge clk);
        chk("rd_wr_first", 32'(ram_addr), 9);
        chk("rd_ready_busy", 32'(rd_ready), 0);
        tick();
        @(negedge clk);
        chk("rd_grant_addr", 32'(ram_addr), 7);
        chk("rd_grant_we", 32'(ram_we), 0);
        tick();
        @(negedge clk);
        chk("rd_dv_early", 32'(rd_data_valid), 0);
        tick();
        @(negedge clk);
        chk("rd_dv", 32'(rd_data_valid), 1);
        chk("rd_data", 32'(rd_data), 32'(init_word(7)));
        chk("rd_ready_free", 32'(rd_ready), 1);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete at h=%0d v=%0d", h_cnt, v_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
